// File: rtl/taillight_decoder.sv
// taillight_decoder
// Receive-side checker for the tail-light lamp bus. Samples the 10-bit lamp
// vector every cycle, classifies each frame change as a left, right or
// hazard animation step (or an illegal pattern), locks onto a mode after
// enough consistent steps, recognises steady IDLE / BRAKE frames after a
// quiet period, and shows the result as a mode code and a HEX0 character.
//
// Optional build macro: TLD_STICKY_ERR_EN
//   defined   : err latches on any fault and clears on reset or KEY[1] low;
//               the HEX0 decimal point is lit while err is set.
//   undefined : err simply mirrors the FAULT state; KEY[1] is ignored and
//               the decimal point stays dark.

module taillight_decoder #(
  parameter int LOCK_STEPS     = 4,
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic       ADC_CLK_10,
  input  logic [1:0] KEY,
  input  logic [9:0] LEDR_IN,
  output logic [2:0] mode,
  output logic       brake,
  output logic       locked,
  output logic       err,
  output logic [7:0] HEX0
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W  = $clog2(LOCK_STEPS + 1);

  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_FIRE = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LOCK  = CNT_W'(LOCK_STEPS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] MODE_NONE   = 3'd0;
  localparam logic [2:0] MODE_IDLE   = 3'd1;
  localparam logic [2:0] MODE_LEFT   = 3'd2;
  localparam logic [2:0] MODE_RIGHT  = 3'd3;
  localparam logic [2:0] MODE_HAZARD = 3'd4;
  localparam logic [2:0] MODE_BRAKE  = 3'd5;
  localparam logic [2:0] MODE_FAULT  = 3'd7;

  // Full-brake frame: all six lamps lit, unused middle bits clear.
  localparam logic [9:0] FRAME_BRAKE = 10'h387;

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP_LEFT,
    STEP_RIGHT,
    STEP_HAZ,
    STEP_ILLEGAL
  } step_t;

  // Side patterns are handled in a common "inner lamp = bit 0" encoding:
  // S0 = 000, S1 = 001, S2 = 011, S3 = 111. The right side is bit-reversed
  // into this form so both sides share one advance rule.
  function automatic logic side_adv(input logic [2:0] p, input logic [2:0] n);
    case (p)
      3'b000:  return n == 3'b001;
      3'b001:  return n == 3'b011;
      3'b011:  return n == 3'b111;
      3'b111:  return n == 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  // A side that is not animating must be fully dark or fully lit.
  function automatic logic side_static(input logic [2:0] s);
    return (s == 3'b000) || (s == 3'b111);
  endfunction

  logic              w_rst_n;
  logic [2:0]        w_lp, w_ln, w_rp, w_rn;
  logic              w_mid_ok;
  logic              w_change;
  logic              w_timeout;
  step_t             w_step;
  logic [IDLE_W-1:0] w_idle_next;
  state_t            w_state_next;
  step_t             w_cand_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [2:0]        w_mode_next;
  logic              w_brake_next;
  logic              w_err_set;
  logic              w_err_next;
  logic              w_dp_next;
  logic [6:0]        w_seg_next;
  logic [7:0]        w_hex_next;

  logic [9:0]        r_frame;
  logic [IDLE_W-1:0] r_idle_cnt;
  state_t            r_state;
  step_t             r_cand;
  logic [CNT_W-1:0]  r_step_cnt;
  logic [2:0]        r_mode;
  logic              r_brake;
  logic              r_locked;
  logic              r_err;
  logic [7:0]        r_hex;

  assign w_rst_n = KEY[0];

  assign w_lp     = r_frame[9:7];
  assign w_ln     = LEDR_IN[9:7];
  assign w_rp     = {r_frame[0], r_frame[1], r_frame[2]};
  assign w_rn     = {LEDR_IN[0], LEDR_IN[1], LEDR_IN[2]};
  assign w_mid_ok = (r_frame[6:3] == 4'd0) && (LEDR_IN[6:3] == 4'd0);
  assign w_change = (LEDR_IN != r_frame);

  // Timeout fires only on the edge where the quiet counter reaches the limit;
  // a change on that same edge takes precedence.
  assign w_timeout = !w_change && (r_idle_cnt == IDLE_FIRE);

  // Classify the transition from the latched frame to the incoming one.
  // NOTE: every variable written in an always_comb gets a default first so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_step = STEP_ILLEGAL;
    if (w_mid_ok) begin
      if (side_adv(w_lp, w_ln) && (w_rp == w_rn) && side_static(w_rn)) begin
        w_step = STEP_LEFT;
      end else if (side_adv(w_rp, w_rn) && (w_lp == w_ln) && side_static(w_ln)) begin
        w_step = STEP_RIGHT;
      end else if (((w_lp == 3'b000) && (w_rp == 3'b000) && (w_ln == 3'b111) && (w_rn == 3'b111)) ||
                   ((w_lp == 3'b111) && (w_rp == 3'b111) && (w_ln == 3'b000) && (w_rn == 3'b000))) begin
        w_step = STEP_HAZ;
      end
    end
  end

  // Quiet-period counter: clears on a change, otherwise counts up and holds.
  always_comb begin
    w_idle_next = r_idle_cnt;
    if (w_change) begin
      w_idle_next = '0;
    end else if (r_idle_cnt != IDLE_MAX) begin
      w_idle_next = r_idle_cnt + IDLE_W'(1);
    end
  end

  // Next-state, candidate tracking and registered-output values.
  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_step_cnt;
    w_mode_next  = r_mode;
    w_brake_next = r_brake;
    w_err_set    = 1'b0;
    if (w_change) begin
      if (w_step == STEP_ILLEGAL) begin
        w_state_next = ST_FAULT;
        w_cand_next  = STEP_NONE;
        w_cnt_next   = '0;
        w_mode_next  = MODE_FAULT;
        w_brake_next = 1'b0;
        w_err_set    = 1'b1;
      end else begin
        // Same type as the one being tracked extends the run; anything else
        // (or any step out of FAULT) starts a fresh run of one.
        if ((r_state != ST_FAULT) && (w_step == r_cand)) begin
          if (r_step_cnt < CNT_LOCK) w_cnt_next = r_step_cnt + CNT_ONE;
        end else begin
          w_cand_next = w_step;
          w_cnt_next  = CNT_ONE;
        end
        if (w_cnt_next >= CNT_LOCK) begin
          w_state_next = ST_LOCKED;
          case (w_step)
            STEP_LEFT: begin
              w_mode_next  = MODE_LEFT;
              w_brake_next = (w_rn == 3'b111);
            end
            STEP_RIGHT: begin
              w_mode_next  = MODE_RIGHT;
              w_brake_next = (w_ln == 3'b111);
            end
            default: begin
              w_mode_next  = MODE_HAZARD;
              w_brake_next = 1'b0;
            end
          endcase
        end else begin
          w_state_next = ST_ACQUIRE;
          w_mode_next  = MODE_NONE;
          w_brake_next = 1'b0;
        end
      end
    end else if (w_timeout) begin
      // A steady frame is not an animation step, so no run is tracked.
      w_cand_next = STEP_NONE;
      w_cnt_next  = '0;
      if (r_frame == 10'd0) begin
        w_state_next = ST_LOCKED;
        w_mode_next  = MODE_IDLE;
        w_brake_next = 1'b0;
      end else if (r_frame == FRAME_BRAKE) begin
        w_state_next = ST_LOCKED;
        w_mode_next  = MODE_BRAKE;
        w_brake_next = 1'b1;
      end else begin
        w_state_next = ST_FAULT;
        w_mode_next  = MODE_FAULT;
        w_brake_next = 1'b0;
        w_err_set    = 1'b1;
      end
    end
  end

`ifdef TLD_STICKY_ERR_EN
  // Sticky error: a new fault on the same edge as a clear keeps err set.
  always_comb begin
    w_err_next = r_err;
    if (w_err_set) begin
      w_err_next = 1'b1;
    end else if (!KEY[1]) begin
      w_err_next = 1'b0;
    end
    w_dp_next = ~w_err_next;
  end
`else
  logic w_unused_clr_n;
  assign w_unused_clr_n = KEY[1];

  // Plain error flag: simply tracks the FAULT state; dp stays dark.
  always_comb begin
    w_err_next = (w_state_next == ST_FAULT);
    w_dp_next  = 1'b1;
  end
`endif

  // Seven-segment character for the upcoming mode (active-low {g..a}).
  always_comb begin
    w_seg_next = 7'h7F;
    case (w_mode_next)
      MODE_IDLE:   w_seg_next = 7'h3F;
      MODE_LEFT:   w_seg_next = 7'h47;
      MODE_RIGHT:  w_seg_next = 7'h2F;
      MODE_HAZARD: w_seg_next = 7'h09;
      MODE_BRAKE:  w_seg_next = 7'h03;
      MODE_FAULT:  w_seg_next = 7'h06;
      default:     w_seg_next = 7'h7F;
    endcase
    w_hex_next = {w_dp_next, w_seg_next};
  end

  // State, frame history, counters and all outputs, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge ADC_CLK_10 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_frame    <= '0;
      r_idle_cnt <= '0;
      r_state    <= ST_ACQUIRE;
      r_cand     <= STEP_NONE;
      r_step_cnt <= '0;
      r_mode     <= MODE_NONE;
      r_brake    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_hex      <= 8'hFF;
    end else begin
      r_frame    <= LEDR_IN;
      r_idle_cnt <= w_idle_next;
      r_state    <= w_state_next;
      r_cand     <= w_cand_next;
      r_step_cnt <= w_cnt_next;
      r_mode     <= w_mode_next;
      r_brake    <= w_brake_next;
      r_locked   <= (w_state_next == ST_LOCKED);
      r_err      <= w_err_next;
      r_hex      <= w_hex_next;
    end
  end

  assign mode   = r_mode;
  assign brake  = r_brake;
  assign locked = r_locked;
  assign err    = r_err;
  assign HEX0   = r_hex;

endmodule

// File: tb/tb_taillight_decoder.sv
// tb_taillight_decoder
// Directed scenarios plus a random walk over lamp frames, each compared
// against a behavioural model that reasons in terms of animation phases
// (0..3 per side) and named step kinds rather than lamp bit patterns.

module tb_taillight_decoder;

  localparam int LOCK_STEPS = 4;
  localparam int TIMEOUT    = 20;

`ifdef TLD_STICKY_ERR_EN
  localparam logic       ERR_AFTER_RELOCK = 1'b1;
  localparam logic [7:0] HEX_FAULT        = 8'h06;
  localparam logic [7:0] HEX_RIGHT_RELOCK = 8'h2F;
`else
  localparam logic       ERR_AFTER_RELOCK = 1'b0;
  localparam logic [7:0] HEX_FAULT        = 8'h86;
  localparam logic [7:0] HEX_RIGHT_RELOCK = 8'hAF;
`endif

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [9:0] ledr;
  logic [2:0] mode;
  logic       brake, locked, err;
  logic [7:0] hex;
  logic [13:0] obs;

  int checks   = 0;
  int failures = 0;

  taillight_decoder #(
    .LOCK_STEPS    (LOCK_STEPS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .ADC_CLK_10(clk),
    .KEY       (key),
    .LEDR_IN   (ledr),
    .mode      (mode),
    .brake     (brake),
    .locked    (locked),
    .err       (err),
    .HEX0      (hex)
  );

  always #5 clk = ~clk;

  assign obs = {mode, brake, locked, err, hex};

  // ---------------- reference model ----------------
  logic [9:0] m_frame;
  int         m_idle;
  string      m_st;     // "ACQ", "LOCK", "FAULT"
  string      m_cand;   // "", "LEFT", "RIGHT", "HAZ"
  int         m_cnt;
  logic [2:0] m_mode;
  logic       m_brake, m_locked, m_err;
  logic [7:0] m_hex;

  function automatic int phase_l(input logic [2:0] s);
    case (s)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int phase_r(input logic [2:0] s);
    case (s)
      3'b000:  return 0;
      3'b100:  return 1;
      3'b110:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit adv(input int a, input int b);
    return (a >= 0) && (b >= 0) && (b == (a + 1) % 4);
  endfunction

  function automatic string classify(input logic [9:0] p, input logic [9:0] n);
    int pl, nl, pr, nr;
    if (p[6:3] != 4'd0 || n[6:3] != 4'd0) return "ILL";
    pl = phase_l(p[9:7]);
    nl = phase_l(n[9:7]);
    pr = phase_r(p[2:0]);
    nr = phase_r(n[2:0]);
    if (adv(pl, nl) && pr == nr && (nr == 0 || nr == 3)) return "LEFT";
    if (adv(pr, nr) && pl == nl && (nl == 0 || nl == 3)) return "RIGHT";
    if ((pl == 0 && pr == 0 && nl == 3 && nr == 3) ||
        (pl == 3 && pr == 3 && nl == 0 && nr == 0)) return "HAZ";
    return "ILL";
  endfunction

  function automatic logic [2:0] mode_of(input string k);
    if (k == "LEFT")  return 3'd2;
    if (k == "RIGHT") return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [7:0] hex_of(input logic [2:0] md, input logic e);
    logic [7:0] h;
    case (md)
      3'd1:    h = 8'hBF;
      3'd2:    h = 8'hC7;
      3'd3:    h = 8'hAF;
      3'd4:    h = 8'h89;
      3'd5:    h = 8'h83;
      3'd7:    h = 8'h86;
      default: h = 8'hFF;
    endcase
`ifdef TLD_STICKY_ERR_EN
    if (e) h[7] = 1'b0;
`endif
    return h;
  endfunction

  function automatic logic [13:0] expv();
    return {m_mode, m_brake, m_locked, m_err, m_hex};
  endfunction

  task automatic model_reset();
    m_frame  = '0;
    m_idle   = 0;
    m_st     = "ACQ";
    m_cand   = "";
    m_cnt    = 0;
    m_mode   = 3'd0;
    m_brake  = 1'b0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_hex    = 8'hFF;
  endtask

  task automatic model_edge(input logic [9:0] v, input logic clr_n);
    string k;
    bit    fault_event = 1'b0;
    if (v != m_frame) begin
      m_idle = 0;
      k = classify(m_frame, v);
      if (k == "ILL") begin
        m_st = "FAULT"; m_cand = ""; m_cnt = 0;
        m_mode = 3'd7; m_brake = 1'b0; fault_event = 1'b1;
      end else begin
        if (m_st != "FAULT" && k == m_cand) begin
          if (m_cnt < LOCK_STEPS) m_cnt++;
        end else begin
          m_cand = k;
          m_cnt  = 1;
        end
        if (m_cnt >= LOCK_STEPS) begin
          m_st    = "LOCK";
          m_mode  = mode_of(k);
          m_brake = (k == "LEFT")  ? (v[2:0] == 3'b111) :
                    (k == "RIGHT") ? (v[9:7] == 3'b111) : 1'b0;
        end else begin
          m_st = "ACQ"; m_mode = 3'd0; m_brake = 1'b0;
        end
      end
    end else if (m_idle < TIMEOUT) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_cand = ""; m_cnt = 0;
        if (m_frame == 10'h000) begin
          m_st = "LOCK"; m_mode = 3'd1; m_brake = 1'b0;
        end else if (m_frame == 10'h387) begin
          m_st = "LOCK"; m_mode = 3'd5; m_brake = 1'b1;
        end else begin
          m_st = "FAULT"; m_mode = 3'd7; m_brake = 1'b0; fault_event = 1'b1;
        end
      end
    end
    m_frame  = v;
    m_locked = (m_st == "LOCK");
`ifdef TLD_STICKY_ERR_EN
    if (fault_event) m_err = 1'b1;
    else if (!clr_n) m_err = 1'b0;
`else
    m_err = (m_st == "FAULT");
`endif
    m_hex = hex_of(m_mode, m_err);
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic cycle(input logic [9:0] v);
    ledr = v;
    @(posedge clk);
    model_edge(v, key[1]);
    #1;
  endtask

  task automatic apply_reset();
    key[0] = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    key[0] = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    key  = 2'b10;
    ledr = 10'h000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (obs !== {3'd0, 1'b0, 1'b0, 1'b0, 8'hFF}) begin
      failures++;
      $display("FAIL reset_values obs=%h exp=%h", obs, {3'd0, 3'b000, 8'hFF});
    end
    checks++;
    @(negedge clk);
    key[0] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cycle(10'h000);
      if (obs !== expv()) begin
        failures++;
        $display("FAIL idle_cycle%0d obs=%h exp=%h", i, obs, expv());
      end
      checks++;
      if (i == TIMEOUT - 2) begin
        if (mode !== 3'd0 || hex !== 8'hFF || locked !== 1'b0) begin
          failures++;
          $display("FAIL idle_before_timeout mode=%0d hex=%h exp mode=0 hex=ff", mode, hex);
        end
        checks++;
      end
      if (i == TIMEOUT - 1) begin
        if (mode !== 3'd1 || hex !== 8'hBF || locked !== 1'b1) begin
          failures++;
          $display("FAIL idle_lock mode=%0d hex=%h locked=%b exp mode=1 hex=bf locked=1",
                   mode, hex, locked);
        end
        checks++;
      end
    end
  endtask

  task automatic test_left();
    logic [9:0] seq [4] = '{10'h080, 10'h180, 10'h380, 10'h000};
    apply_reset();
    foreach (seq[s]) begin
      for (int c = 0; c < 4; c++) begin
        cycle(seq[s]);
        if (obs !== expv()) begin
          failures++;
          $display("FAIL left_s%0d_c%0d obs=%h exp=%h", s, c, obs, expv());
        end
        checks++;
      end
    end
    if (mode !== 3'd2 || hex !== 8'hC7 || locked !== 1'b1 || brake !== 1'b0) begin
      failures++;
      $display("FAIL left_lock mode=%0d hex=%h locked=%b brake=%b exp 2 c7 1 0",
               mode, hex, locked, brake);
    end
    checks++;
  endtask

  task automatic test_left_brake();
    logic [9:0] seq [6] = '{10'h007, 10'h087, 10'h187, 10'h387, 10'h007, 10'h087};
    apply_reset();
    foreach (seq[s]) begin
      for (int c = 0; c < 3; c++) begin
        cycle(seq[s]);
        if (obs !== expv()) begin
          failures++;
          $display("FAIL lbrake_s%0d_c%0d obs=%h exp=%h", s, c, obs, expv());
        end
        checks++;
      end
    end
    if (mode !== 3'd2 || brake !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL left_brake mode=%0d brake=%b locked=%b exp 2 1 1", mode, brake, locked);
    end
    checks++;
  endtask

  task automatic test_hazard_brake();
    logic [9:0] seq [5] = '{10'h387, 10'h000, 10'h387, 10'h000, 10'h387};
    apply_reset();
    foreach (seq[s]) begin
      for (int c = 0; c < 3; c++) begin
        cycle(seq[s]);
        if (obs !== expv()) begin
          failures++;
          $display("FAIL haz_s%0d_c%0d obs=%h exp=%h", s, c, obs, expv());
        end
        checks++;
      end
      if (s == 3) begin
        if (mode !== 3'd4 || hex !== 8'h89 || brake !== 1'b0) begin
          failures++;
          $display("FAIL hazard_lock mode=%0d hex=%h brake=%b exp 4 89 0", mode, hex, brake);
        end
        checks++;
      end
    end
    for (int c = 0; c < 25; c++) begin
      cycle(10'h387);
      if (obs !== expv()) begin
        failures++;
        $display("FAIL brake_hold_c%0d obs=%h exp=%h", c, obs, expv());
      end
      checks++;
    end
    if (mode !== 3'd5 || hex !== 8'h83 || brake !== 1'b1) begin
      failures++;
      $display("FAIL brake_lock mode=%0d hex=%h brake=%b exp 5 83 1", mode, hex, brake);
    end
    checks++;
  endtask

  task automatic test_illegal_recover();
    logic [9:0] lseq [5] = '{10'h080, 10'h180, 10'h380, 10'h000, 10'h080};
    logic [9:0] rseq [5] = '{10'h000, 10'h004, 10'h006, 10'h007, 10'h000};
    apply_reset();
    foreach (lseq[s]) repeat (2) cycle(lseq[s]);
    cycle(10'h280);
    if (mode !== 3'd7 || err !== 1'b1 || hex !== HEX_FAULT) begin
      failures++;
      $display("FAIL illegal_skip mode=%0d err=%b hex=%h exp 7 1 %h", mode, err, hex, HEX_FAULT);
    end
    checks++;
    foreach (rseq[s]) begin
      for (int c = 0; c < 2; c++) begin
        cycle(rseq[s]);
        if (obs !== expv()) begin
          failures++;
          $display("FAIL relock_s%0d_c%0d obs=%h exp=%h", s, c, obs, expv());
        end
        checks++;
      end
    end
    if (mode !== 3'd3 || locked !== 1'b1 || hex !== HEX_RIGHT_RELOCK || err !== ERR_AFTER_RELOCK) begin
      failures++;
      $display("FAIL right_relock mode=%0d locked=%b hex=%h err=%b exp 3 1 %h %b",
               mode, locked, hex, err, HEX_RIGHT_RELOCK, ERR_AFTER_RELOCK);
    end
    checks++;
    key[1] = 1'b0;
    cycle(10'h000);
    key[1] = 1'b1;
    cycle(10'h000);
    if (err !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL err_clear obs=%h exp=%h", obs, expv());
    end
    checks++;
  endtask

  task automatic test_mid_bits_and_reset();
    logic [9:0] seq [4] = '{10'h080, 10'h180, 10'h380, 10'h000};
    apply_reset();
    cycle(10'h010);
    if (mode !== 3'd7 || locked !== 1'b0) begin
      failures++;
      $display("FAIL mid_bits mode=%0d locked=%b exp 7 0", mode, locked);
    end
    checks++;
    cycle(10'h080);
    cycle(10'h180);
    key[0] = 1'b0;
    #2;
    if (obs !== {3'd0, 1'b0, 1'b0, 1'b0, 8'hFF}) begin
      failures++;
      $display("FAIL async_reset obs=%h exp=%h", obs, {3'd0, 3'b000, 8'hFF});
    end
    checks++;
    model_reset();
    @(negedge clk);
    key[0] = 1'b1;
    foreach (seq[s]) cycle(seq[s]);
    if (mode !== 3'd2 || locked !== 1'b1 || obs !== expv()) begin
      failures++;
      $display("FAIL reacquire obs=%h exp=%h", obs, expv());
    end
    checks++;
  endtask

  task automatic test_timeout_edge();
    apply_reset();
    repeat (TIMEOUT - 1) cycle(10'h000);
    cycle(10'h080);
    if (mode !== 3'd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL change_on_timeout mode=%0d locked=%b exp 0 0", mode, locked);
    end
    checks++;
    repeat (TIMEOUT - 1) cycle(10'h080);
    if (mode !== 3'd0 || obs !== expv()) begin
      failures++;
      $display("FAIL idle_restart_early mode=%0d exp 0", mode);
    end
    checks++;
    cycle(10'h080);
    if (mode !== 3'd7 || obs !== expv()) begin
      failures++;
      $display("FAIL nonsteady_timeout mode=%0d exp 7", mode);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [9:0] pool [16];
    logic [9:0] legal [$];
    logic [9:0] nxt;
    int         hold, r, total;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        pool[a*4+b] = {(a == 0) ? 3'b000 : (a == 1) ? 3'b001 : (a == 2) ? 3'b011 : 3'b111,
                       4'b0000,
                       (b == 0) ? 3'b000 : (b == 1) ? 3'b100 : (b == 2) ? 3'b110 : 3'b111};
    apply_reset();
    total = 0;
    while (total < 600) begin
      legal.delete();
      foreach (pool[p]) if (classify(m_frame, pool[p]) != "ILL") legal.push_back(pool[p]);
      r = $urandom_range(0, 99);
      if (r < 85 && legal.size() > 0) nxt = legal[$urandom_range(0, legal.size() - 1)];
      else if (r < 95)                nxt = pool[$urandom_range(0, 15)];
      else                            nxt = 10'($urandom);
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 3)
                                         : $urandom_range(1, 4);
      for (int c = 0; c < hold; c++) begin
        key[1] = ($urandom_range(0, 19) != 0);
        cycle(nxt);
        total++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL random_t%0d frame=%h obs=%h exp=%h", total, nxt, obs, expv());
        end
        checks++;
      end
    end
    key[1] = 1'b1;
  endtask

  initial begin
    key  = 2'b10;
    ledr = 10'h000;
    test_reset();
    test_left();
    test_left_brake();
    test_hazard_brake();
    test_illegal_recover();
    test_mid_bits_and_reset();
    test_timeout_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/taillight_decoder.md
# taillight_decoder

Receive-side decoder for the tail-light controller: samples the 10-bit lamp vector that the `manual` controller drives on LEDR, tracks its animation frame by frame, and reports the detected mode (idle, left, right, hazard, brake, fault) as a code and as a character on a seven-segment digit. It sits on the far end of the LEDR bus, either on-board as a self-check or in simulation as a pattern checker. All logic runs in the controller's clock domain; no synchronizer is required.

## Interface
- `LOCK_STEPS`, 4: consecutive legal steps of one type required to lock.
- `TIMEOUT_CYCLES`, 20: cycles with no frame change before the frame is classified as steady. The idle counter width is `$clog2(TIMEOUT_CYCLES+1)` and saturates.
- `ADC_CLK_10`  in  1  clock, rising edge.
- `KEY`  in  2  `KEY[0]` is the reset, asynchronous and active-low. `KEY[1]` is the active-low error-clear pushbutton.
- `LEDR_IN`  in  10  observed lamp vector. Left lamps: `[7]` inner, `[8]` mid, `[9]` outer. Right lamps: `[2]` inner, `[1]` mid, `[0]` outer. `[6:3]` must be 0.
- `mode`  out  3  0 NONE, 1 IDLE, 2 LEFT, 3 RIGHT, 4 HAZARD, 5 BRAKE, 7 FAULT.
- `brake`  out  1  brake lamps detected (steady BRAKE, or the non-turning side held at 111 during a turn).
- `locked`  out  1  mode is confirmed.
- `err`  out  1  illegal pattern seen.
- `HEX0`  out  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}.

## Operation
- `frame` register latches `LEDR_IN` every cycle. A change is `LEDR_IN != frame`.
- Side states, left `[9:7]` / right `[2:0]`: S0 = 000/000, S1 = 001/100, S2 = 011/110, S3 = 111/111.
- Legal advance per side: S0→S1→S2→S3→S0.
- Step classification on each change, prev = `frame`, new = `LEDR_IN`:
  - LEFT_STEP: left side makes a legal advance; right side unchanged and equal to 000 or 111.
  - RIGHT_STEP: the mirror of LEFT_STEP.
  - HAZ_STEP: both sides toggle together, 000↔111.
  - ILLEGAL: anything else, including any nonzero `[6:3]`.
- FSM states are ACQUIRE (reset), LOCKED, FAULT. It keeps a candidate type and a `step_cnt`.
- ACQUIRE:
  - A legal step matching the candidate increments `step_cnt`.
  - A legal step of a different type sets a new candidate with `step_cnt` = 1.
  - When `step_cnt` reaches `LOCK_STEPS`, go to LOCKED with the mode from the candidate.
- LOCKED:
  - A matching step stays LOCKED.
  - A legal step of a different type goes to ACQUIRE with `step_cnt` = 1.
- ILLEGAL in any state goes to FAULT with `mode` = 7 and sets `err`.
- FAULT:
  - A legal step goes to ACQUIRE with `step_cnt` = 1.
  - A legal steady timeout goes to LOCKED.
- Steady timeout: when `idle_cnt` reaches `TIMEOUT_CYCLES`:
  - `frame` all-zero → LOCKED IDLE.
  - `frame` = 111 on both sides with `[6:3]` = 0 → LOCKED BRAKE.
  - Any other frame → FAULT.
- `brake` during LEFT or RIGHT reflects the static side (111 → 1, 000 → 0), updated on each step.
- HEX0 by mode:
  - IDLE '-' 8'hBF
  - LEFT 'L' 8'hC7
  - RIGHT 'r' 8'hAF
  - HAZARD 'H' 8'h89
  - BRAKE 'b' 8'h83
  - FAULT 'E' 8'h86
  - NONE or ACQUIRE blank 8'hFF
- The dp bit is set according to Configuration.

## Timing
- Reset values: `mode` = 0, `brake` = 0, `locked` = 0, `err` = 0, `HEX0` = 8'hFF, `frame` = 0, both counters = 0, state ACQUIRE.
- Latency: a change on `LEDR_IN` before edge t is classified at edge t. `mode`, `locked`, `brake`, `err` and `HEX0` are registered and reflect it at edge t, i.e. valid in the cycle after t.
- `idle_cnt` clears on any change and increments otherwise. The timeout fires on the edge where it reaches `TIMEOUT_CYCLES`. It then saturates and does not re-fire until the next change.
- A change and the timeout on the same edge: the change wins and the timeout is ignored.
- The first frame after reset compares against `frame` = 0, so 0 → left S1 counts as LEFT_STEP.
- Reset asserted mid-sequence: all registers clear immediately (asynchronously), and acquisition restarts after release.
- Hazard on-phase equals BRAKE; only the timeout distinguishes them. An animating hazard never produces BRAKE.

## Configuration
- `TLD_STICKY_ERR_EN` defined:
  - `err` is sticky and is cleared only by reset or `KEY[1]` low.
  - dp = 0 (lit) while `err` is set.
  - A clear and a new ILLEGAL on the same edge: set wins.
- Undefined:
  - `err` = (state == FAULT).
  - `KEY[1]` is ignored.
  - dp is always 1.

## Test plan
- Reset with `LEDR_IN` = 0 held 25 cycles → `mode` = 1, `locked` = 1, `HEX0` = 8'hBF after `TIMEOUT_CYCLES`. Before that, `mode` = 0 and `HEX0` = 8'hFF.
- Left animation 0→0x080→0x180→0x380→0, one frame per 4 cycles → `locked` at the 4th step, `mode` = 2, `HEX0` = 8'hC7, `brake` = 0. With right side held at 0x007 → `brake` = 1.
- Hazard toggling 0x000↔0x387 every 3 cycles → `mode` = 4, `HEX0` = 8'h89. Then hold 0x387 for 25 cycles → `mode` = 5, `HEX0` = 8'h83.
- While locked LEFT, apply 0x080→0x280 (illegal skip) → `mode` = 7, `err` = 1, `HEX0` = 8'h86 (dp lit with `TLD_STICKY_ERR_EN`). Resume a legal right sequence → relock at RIGHT 8'hAF; `err` stays 1 until `KEY[1]` is pulsed low.
- Drive `LEDR_IN[4]` = 1 → FAULT. Assert `KEY[0]` low mid-sequence → all outputs return to reset values the same cycle.
- Apply a change exactly on the timeout edge → no IDLE/BRAKE lock and `idle_cnt` restarts.
